platform_land_scan: RTL and testbench

Multi-platform landing detector for the physics stage. Once per frame it scans a parametrised table of one-way platforms one entry per clock and tests the player's bounding box for a downward crossing of each platform top. It reports the winning platform and the snapped landing Y, and supports drop-through of non-solid platforms for a programmable number of frames. It sits between the position integrator (`next_y`) and the player state machine.

---
 rtl/platform_land_scan_pkg.sv | 34 +++
 rtl/platform_land_scan_if.sv | 33 +++
 rtl/platform_land_scan_hit.sv | 43 ++++
 rtl/platform_land_scan.sv | 166 ++++++++++++++++
 tb/tb_platform_land_scan.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/platform_land_scan_pkg.sv
// platform_pkg: shared constants for the platform landing scanner.
//   NUM_PLT_MAX  - capacity of the platform table.
//   PLT_X/Y/W    - left X, top Y and width of each platform (pixels).
//   PLT_SOLID    - bit i set means platform i cannot be dropped through.
//   scan_state_t - scanner FSM state, also exported for debug.
package platform_pkg;

  localparam int NUM_PLT_MAX = 16;

  // Entry 0 is the floor; entries 1 and 2 are one-way ledges.
  localparam logic [9:0] PLT_X [NUM_PLT_MAX] = '{
    10'd0,   10'd420, 10'd100, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0,
    10'd0,   10'd0,   10'd0,   10'd0, 10'd0, 10'd0, 10'd0, 10'd0
  };

  localparam logic [9:0] PLT_Y [NUM_PLT_MAX] = '{
    10'd400, 10'd215, 10'd215, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0,
    10'd0,   10'd0,   10'd0,   10'd0, 10'd0, 10'd0, 10'd0, 10'd0
  };

  localparam logic [9:0] PLT_W [NUM_PLT_MAX] = '{
    10'd640, 10'd105, 10'd105, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0,
    10'd0,   10'd0,   10'd0,   10'd0, 10'd0, 10'd0, 10'd0, 10'd0
  };

  localparam logic [NUM_PLT_MAX-1:0] PLT_SOLID = 16'h0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/platform_land_scan_if.sv
// platform_land_scan_if: frame request and landing result bundle.
//   master (physics driver): start, x_pos, y_pos, next_y, drop_req
//   slave  (scanner)       : busy, done, landed, plt_idx, snap_y, state
// Handshake: start is a single-cycle request honoured only while busy is
// low; done is a single-cycle pulse marking landed/plt_idx/snap_y as fresh.
// The results then stay stable until the next done. There is no
// backpressure and no queueing: a start seen while busy is dropped.
interface platform_land_scan_if;
  import platform_pkg::*;

  logic        start;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [9:0]  next_y;
  logic        drop_req;
  logic        busy;
  logic        done;
  logic        landed;
  logic [3:0]  plt_idx;
  logic [9:0]  snap_y;
  scan_state_t state;

  modport master (
    output start, x_pos, y_pos, next_y, drop_req,
    input  busy, done, landed, plt_idx, snap_y, state
  );

  modport slave (
    input  start, x_pos, y_pos, next_y, drop_req,
    output busy, done, landed, plt_idx, snap_y, state
  );

endinterface

// File: rtl/platform_land_scan_hit.sv
// plt_hit_test: combinational test of one platform against the player box.
//   x, y, next_y : player left X, top Y now, top Y next frame
//   px, py, pw   : platform left X, top Y, width
//   masked       : platform currently ignored (drop-through)
//   hit          : feet cross the platform top this frame, box overlaps in X
// All sums are 11 bits wide so nothing wraps.
module plt_hit_test #(
  parameter int WIDTH  = 23,
  parameter int HEIGHT = 30,
  parameter int SCALE  = 2
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] next_y,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [9:0] pw,
  input  logic       masked,
  output logic       hit
);

  localparam logic [10:0] BOX_H = 11'(HEIGHT * SCALE);
  localparam logic [10:0] BOX_W = 11'(WIDTH * SCALE);

  logic [10:0] feet_now;
  logic [10:0] feet_next;
  logic [10:0] right_edge;
  logic [10:0] plt_right;

  assign feet_now   = {1'b0, y} + BOX_H;
  assign feet_next  = {1'b0, next_y} + BOX_H;
  assign right_edge = {1'b0, x} + BOX_W;
  assign plt_right  = {1'b0, px} + {1'b0, pw};

  // Feet at or above the top now, at or below it next frame: a downward
  // crossing. A player already below the top never lands on it (one-way).
  assign hit = (feet_now <= {1'b0, py}) &&
               (feet_next >= {1'b0, py}) &&
               (right_edge >= {1'b0, px}) &&
               ({1'b0, x} <= plt_right) &&
               !masked;

endmodule

// File: rtl/platform_land_scan.sv
// platform_land_scan: once-per-frame landing detector.
//   clk, rst : clock, synchronous active-high reset
//   bus      : platform_land_scan_if.slave (request in, result out)
// A start pulse latches the player position, then one table entry is
// tested per clock. The hit with the smallest platform top Y wins (first
// top crossed); ties go to the lower index because later equal entries
// never displace the held candidate. Results register on the last scan
// edge and done pulses for the following cycle.
module platform_land_scan
  import platform_pkg::*;
#(
  parameter int NUM_PLT     = 3,
  parameter int WIDTH       = 23,
  parameter int HEIGHT      = 30,
  parameter int SCALE       = 2,
  parameter int DROP_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  platform_land_scan_if.slave bus
);

  localparam logic [9:0] BOX_H10  = 10'(HEIGHT * SCALE);
  localparam logic [3:0] LAST_IDX = 4'(NUM_PLT - 1);
  localparam logic [7:0] DROP_LD  = 8'(DROP_FRAMES);

  scan_state_t state;
  scan_state_t state_nxt;

  logic [3:0] idx;
  logic [9:0] lat_x;
  logic [9:0] lat_y;
  logic [9:0] lat_ny;

  logic [7:0] drop_cnt;
  logic [3:0] drop_idx;

  logic       best_valid;
  logic [3:0] best_idx;
  logic [9:0] best_py;

  logic       landed_q;
  logic [3:0] plt_idx_q;
  logic [9:0] snap_y_q;

  logic [9:0] cur_px;
  logic [9:0] cur_py;
  logic [9:0] cur_pw;
  logic       cur_masked;
  logic       cur_hit;
  logic       take;
  logic       fin_valid;
  logic [3:0] fin_idx;
  logic [9:0] fin_py;
  logic       last;
  logic       drop_ok;

  // Entry mux feeding the single shared hit tester.
  assign cur_px     = PLT_X[idx];
  assign cur_py     = PLT_Y[idx];
  assign cur_pw     = PLT_W[idx];
  assign cur_masked = (drop_cnt != 8'd0) && (idx == drop_idx);
  assign last       = (idx == LAST_IDX);

  plt_hit_test #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .SCALE  (SCALE)
  ) u_hit (
    .x      (lat_x),
    .y      (lat_y),
    .next_y (lat_ny),
    .px     (cur_px),
    .py     (cur_py),
    .pw     (cur_pw),
    .masked (cur_masked),
    .hit    (cur_hit)
  );

  // Strict less-than keeps the earlier (lower) index on equal tops.
  assign take      = cur_hit && (!best_valid || (cur_py < best_py));
  assign fin_valid = best_valid || take;
  assign fin_idx   = take ? idx : best_idx;
  assign fin_py    = take ? cur_py : best_py;

  // Drop-through only applies to a non-solid platform we are standing on.
  assign drop_ok = bus.drop_req && landed_q && !PLT_SOLID[plt_idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SCAN;
      SCAN:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 4'd0;
      lat_x      <= 10'd0;
      lat_y      <= 10'd0;
      lat_ny     <= 10'd0;
      drop_cnt   <= 8'd0;
      drop_idx   <= 4'd0;
      best_valid <= 1'b0;
      best_idx   <= 4'd0;
      best_py    <= 10'd0;
      landed_q   <= 1'b0;
      plt_idx_q  <= 4'd0;
      snap_y_q   <= 10'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            lat_x      <= bus.x_pos;
            lat_y      <= bus.y_pos;
            lat_ny     <= bus.next_y;
            idx        <= 4'd0;
            best_valid <= 1'b0;
            best_idx   <= 4'd0;
            best_py    <= 10'd0;
            if (drop_ok) begin
              drop_idx <= plt_idx_q;
              drop_cnt <= DROP_LD;
            end
          end
        end
        SCAN: begin
          best_valid <= fin_valid;
          best_idx   <= fin_idx;
          best_py    <= fin_py;
          if (last) begin
            landed_q  <= fin_valid;
            plt_idx_q <= fin_valid ? fin_idx : 4'd0;
            snap_y_q  <= fin_valid ? (fin_py - BOX_H10) : 10'd0;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          // One scan of drop-through consumed.
          if (drop_cnt != 8'd0) drop_cnt <= drop_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.landed  = landed_q;
  assign bus.plt_idx = plt_idx_q;
  assign bus.snap_y  = snap_y_q;
  assign bus.state   = state;

endmodule

// File: tb/tb_platform_land_scan.sv
// Directed bench for platform_land_scan using the default platform table
// and a 46x60 player box. Expected results are hand-computed.
module tb_platform_land_scan;
  import platform_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [14:0] exp_q[$];

  platform_land_scan_if bus ();

  platform_land_scan #(
    .NUM_PLT     (3),
    .WIDTH       (23),
    .HEIGHT      (30),
    .SCALE       (2),
    .DROP_FRAMES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.x_pos    = '0;
    bus.y_pos    = '0;
    bus.next_y   = '0;
    bus.drop_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // driver: one frame request, waits (bounded) for done.
  // lat counts negedges from the one after the start edge until done.
  task automatic run_scan(input logic [9:0] x, input logic [9:0] y,
                          input logic [9:0] ny, input logic drop,
                          output int lat, output logic busy0,
                          output logic [14:0] got);
    @(negedge clk);
    bus.x_pos    = x;
    bus.y_pos    = y;
    bus.next_y   = ny;
    bus.drop_req = drop;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.drop_req = 1'b0;
    busy0 = bus.busy;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = {bus.landed, bus.plt_idx, bus.snap_y};
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks += 6;
    if (bus.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", bus.state, IDLE); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    if (bus.landed !== 1'b0) begin n_fail++; $display("FAIL reset_landed: got %b expected 0", bus.landed); end
    if (bus.plt_idx !== 4'd0) begin n_fail++; $display("FAIL reset_plt_idx: got %0d expected 0", bus.plt_idx); end
    if (bus.snap_y !== 10'd0) begin n_fail++; $display("FAIL reset_snap_y: got %0d expected 0", bus.snap_y); end
  endtask

  // scan with expected result from exp_q; also checks timing
  task automatic scan_expect(input string name, input logic [9:0] x,
                             input logic [9:0] y, input logic [9:0] ny,
                             input logic drop);
    int lat;
    logic busy0;
    logic [14:0] got;
    logic [14:0] exp;
    run_scan(x, y, ny, drop, lat, busy0, got);
    exp = exp_q.pop_front();
    n_checks += 3;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b expected 1", name, busy0); end
    if (lat != 3) begin n_fail++; $display("FAIL %s_latency: got %0d expected 3", name, lat); end
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_result: got landed=%b idx=%0d snap=%0d expected landed=%b idx=%0d snap=%0d",
               name, got[14], got[13:10], got[9:0], exp[14], exp[13:10], exp[9:0]);
    end
  endtask

  task automatic test_single_ledge();
    exp_q.push_back({1'b1, 4'd1, 10'd155});
    scan_expect("ledge1", 10'd450, 10'd150, 10'd160, 1'b0);
    // done lasts one cycle, FSM is idle again, results held
    @(negedge clk);
    n_checks += 3;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b expected 0", bus.done); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    if ({bus.landed, bus.plt_idx, bus.snap_y} !== {1'b1, 4'd1, 10'd155}) begin
      n_fail++; $display("FAIL held_result: got idx=%0d snap=%0d expected idx=1 snap=155", bus.plt_idx, bus.snap_y);
    end
  endtask

  task automatic test_miss_then_floor();
    exp_q.push_back({1'b0, 4'd0, 10'd0});
    scan_expect("miss", 10'd360, 10'd150, 10'd160, 1'b0);
    exp_q.push_back({1'b1, 4'd0, 10'd340});
    scan_expect("floor", 10'd360, 10'd335, 10'd345, 1'b0);
  endtask

  task automatic test_priority();
    exp_q.push_back({1'b1, 4'd2, 10'd155});
    scan_expect("two_cross", 10'd150, 10'd150, 10'd345, 1'b0);
  endtask

  task automatic test_drop_through();
    exp_q.push_back({1'b1, 4'd1, 10'd155});
    scan_expect("drop_land", 10'd450, 10'd155, 10'd157, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, 4'd0, 10'd0});
      scan_expect($sformatf("drop_masked%0d", i), 10'd450, 10'd155, 10'd157, (i == 0));
    end
    exp_q.push_back({1'b1, 4'd1, 10'd155});
    scan_expect("drop_expired", 10'd450, 10'd155, 10'd157, 1'b0);
    // floor is solid: request ignored
    exp_q.push_back({1'b1, 4'd0, 10'd340});
    scan_expect("floor_land", 10'd360, 10'd335, 10'd345, 1'b0);
    exp_q.push_back({1'b1, 4'd0, 10'd340});
    scan_expect("floor_drop", 10'd360, 10'd335, 10'd345, 1'b1);
  endtask

  task automatic test_start_during_scan();
    int dones;
    logic [14:0] got;
    dones = 0;
    got = '0;
    @(negedge clk);
    bus.x_pos = 10'd150; bus.y_pos = 10'd150; bus.next_y = 10'd345;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    // different inputs with a stray start mid-scan
    bus.x_pos = 10'd450; bus.y_pos = 10'd150; bus.next_y = 10'd160;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.done) begin dones++; got = {bus.landed, bus.plt_idx, bus.snap_y}; end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) begin dones++; got = {bus.landed, bus.plt_idx, bus.snap_y}; end
    end
    n_checks += 2;
    if (dones != 1) begin n_fail++; $display("FAIL stray_start_dones: got %0d expected 1", dones); end
    if (got !== {1'b1, 4'd2, 10'd155}) begin
      n_fail++; $display("FAIL stray_start_result: got idx=%0d snap=%0d expected idx=2 snap=155", got[13:10], got[9:0]);
    end
  endtask

  task automatic test_reset_mid_scan();
    int dones;
    dones = 0;
    exp_q.push_back({1'b1, 4'd1, 10'd155});
    scan_expect("pre_rst", 10'd450, 10'd155, 10'd157, 1'b0);
    // start with a valid drop request, then reset sampled at edge T+2
    @(negedge clk);
    bus.x_pos = 10'd450; bus.y_pos = 10'd155; bus.next_y = 10'd157;
    bus.drop_req = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.drop_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (bus.done) dones++;
    n_checks += 4;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    if ({bus.landed, bus.plt_idx, bus.snap_y} !== 15'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got landed=%b idx=%0d snap=%0d expected all 0", bus.landed, bus.plt_idx, bus.snap_y);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    if (dones != 0) begin n_fail++; $display("FAIL rst_mid_done: got %0d expected 0", dones); end
    if (bus.state !== IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected %0d", bus.state, IDLE); end
    // drop state was cleared by reset, so ledge 1 is landable again
    exp_q.push_back({1'b1, 4'd1, 10'd155});
    scan_expect("post_rst", 10'd450, 10'd155, 10'd157, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_ledge();
    test_miss_then_floor();
    test_priority();
    test_drop_through();
    test_start_during_scan();
    test_reset_mid_scan();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
